// File: rtl/tmac_stream_ctrl.sv
// tmac_stream_ctrl: job sequencer for one MAC16 unary multiply-accumulate unit.
// Handshakes a job in, pulses loadA/loadB for one cycle, runs the bitstream for
// STREAM_LEN cycles counting ones on mac_bit, then offers the count on a
// valid/ready result channel. abort drops the job from any state.
// Ports: clk, rst_n (async, active low), start_valid/start_ready, abort,
//   loadA, loadB, mac_bit, mac_stop, res_valid/res_ready, res_data, busy.
// Option: define TMAC_CTRL_EARLY_STOP_EN to let mac_stop end a run early.
module tmac_stream_ctrl #(
  parameter int STREAM_LEN = 256,
  parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic             loadA,
  output logic             loadB,
  input  logic             mac_bit,
  input  logic             mac_stop,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(STREAM_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STREAM_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic             start_ready_q, start_ready_d;
  logic             load_q, load_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             run_last;

`ifdef TMAC_CTRL_EARLY_STOP_EN
  // the stop cycle's own bit is still counted
  assign run_last = (run_q == LAST) || mac_stop;
`else
  logic unused_mac_stop;
  assign unused_mac_stop = mac_stop;
  assign run_last = (run_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    run_d   = run_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        ones_d  = '0;
        run_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mac_bit && (ones_q != LEN)) ones_d = ones_q + CNT_W'(1);
        if (run_q != LEN) run_d = run_q + CNT_W'(1);
        if (run_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // outputs are decoded from the next state so they change with the state flop
  always_comb begin
    start_ready_d = (state_d == S_IDLE);
    load_d        = (state_d == S_LOAD);
    busy_d        = (state_d != S_IDLE);
    res_valid_d   = (state_d == S_DONE);
    res_data_d    = '0;
    if (state_d == S_DONE) begin
      res_data_d = (state_q == S_RUN) ? ones_d : res_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ones_q        <= '0;
      run_q         <= '0;
      res_data_q    <= '0;
      start_ready_q <= 1'b0;
      load_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      run_q         <= run_d;
      res_data_q    <= res_data_d;
      start_ready_q <= start_ready_d;
      load_q        <= load_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign start_ready = start_ready_q;
  assign loadA       = load_q;
  assign loadB       = load_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tmac_stream_ctrl.sv
// tb_tmac_stream_ctrl: directed and randomised jobs for tmac_stream_ctrl,
// checked against a count-of-ones reference model.
module tb_tmac_stream_ctrl;

  localparam int L = 256;
  localparam int W = $clog2(L + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         abort = 1'b0;
  logic         loadA, loadB;
  logic         mac_bit = 1'b0;
  logic         mac_stop = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] pat;

  always #5 clk = ~clk;

  tmac_stream_ctrl #(.STREAM_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .loadA(loadA), .loadB(loadB),
    .mac_bit(mac_bit), .mac_stop(mac_stop),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // index of the last RUN cycle that contributes, from the job's stop request
  function automatic int last_cycle(input int stop_at);
    int last;
    last = L - 1;
`ifdef TMAC_CTRL_EARLY_STOP_EN
    if (stop_at >= 0 && stop_at < L) last = stop_at;
`endif
    return last;
  endfunction

  function automatic int model_count(input logic [L-1:0] p, input int stop_at);
    int n;
    n = 0;
    for (int i = 0; i <= last_cycle(stop_at); i++) n += int'(p[i]);
    if (n > L) n = L;
    return n;
  endfunction

  // waits for start_ready, hands over a job; returns in the LOAD cycle
  task automatic offer(input string tag);
    int k;
    k = 0;
    while (start_ready !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_ready_to"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    mac_bit = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check({tag, "_load"}, {30'd0, loadA, loadB}, 32'd3);
  endtask

  // runs the stream from the LOAD cycle, then collects the result
  task automatic finish_job(input string tag, input logic [L-1:0] p,
                            input int stop_at, input int hold);
    int  lat;
    bit  stable;
    logic [W-1:0] d0;
    lat = 0;
    for (int i = 0; i < L + 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (res_valid === 1'b1) break;
      mac_bit  = (i < L) ? p[i] : 1'b0;
      mac_stop = (i == stop_at);
    end
    mac_bit  = 1'b0;
    mac_stop = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(last_cycle(stop_at) + 2));
    check({tag, "_data"}, 32'(res_data), 32'(model_count(p, stop_at)));
    d0 = res_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_data !== d0 || start_ready !== 1'b0)
        stable = 1'b0;
    end
    check({tag, "_hold"}, 32'(stable), 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, res_valid, start_ready}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_out", {27'd0, start_ready, loadA, loadB, res_valid, busy},
          32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_ready", 32'(start_ready), 32'd1);

    // all ones
    pat = '1;
    offer("t1");
    finish_job("t1", pat, -1, 0);

    // alternating from the first RUN cycle; LOAD bit forced to 1 in offer
    for (int i = 0; i < L; i++) pat[i] = (i % 2 == 0);
    offer("t2");
    finish_job("t2", pat, -1, 0);

    // result held 20 cycles
    for (int i = 0; i < L; i++) pat[i] = 1'($urandom_range(0, 1));
    offer("t3");
    finish_job("t3", pat, -1, 20);

    // randomised jobs
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < L; i++) pat[i] = ($urandom_range(0, 3) != 0);
      offer("rnd");
      finish_job("rnd", pat, -1, int'($urandom_range(0, 5)));
    end

    // abort at RUN cycle 50 with start_valid held high
    offer("t4");
    @(posedge clk); #1;
    mac_bit = 1'b1;
    repeat (49) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;
    check("t4_abort", {28'd0, busy, res_valid, loadA, start_ready}, 32'd1);
    abort = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("t4_reaccept", {30'd0, loadA, loadB}, 32'd3);
    for (int i = 0; i < L; i++) pat[i] = 1'($urandom_range(0, 1));
    finish_job("t4", pat, -1, 0);

    // reset at RUN cycle 100
    offer("t5");
    @(posedge clk); #1;
    repeat (99) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst", {27'd0, start_ready, loadA, loadB, res_valid, busy},
          32'd0);
    check("t5_rst_data", 32'(res_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pat = '1;
    offer("t5b");
    finish_job("t5b", pat, -1, 0);

    // mac_stop at RUN cycle 100 (index 99)
    pat = '1;
    offer("t6");
    finish_job("t6", pat, 99, 0);
`ifdef TMAC_CTRL_EARLY_STOP_EN
    check("t6_const", 32'(model_count(pat, 99)), 32'd100);
`else
    check("t6_const", 32'(model_count(pat, 99)), 32'd256);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
